// File: rtl/vram_arbiter.sv
// VRAM arbiter: VDP slots own the RAM outright; the aux port gets the remaining cycles.
// Define VRAM_ARB_STATS_EN to build the VDP/aux access counters. Without it, vdp_cnt and aux_cnt read zero.
module vram_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int STARVE_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vdp_slot,
    input  logic              vdp_we,
    input  logic [ADDR_W-1:0] vdp_addr,
    input  logic [7:0]        vdp_wdata,
    output logic [7:0]        vdp_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_wdata,
    output logic              aux_ack,
    output logic [7:0]        aux_rdata,
    output logic              aux_starve,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    input  logic [7:0]        ram_dout,
    output logic [15:0]       vdp_cnt,
    output logic [15:0]       aux_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    localparam int BLK_W = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(STARVE_LIMIT);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] lastAddr_q;
    logic [7:0]        auxRdata_q;
    logic [7:0]        vdpRdata_q;
    logic              vdpRdPend_q;
    logic [BLK_W-1:0]  blkCnt_q, blkCnt_d;
    logic              starve_q, starve_d;
    logic              auxIssue;
    logic              auxBlocked;

    always_comb begin
        auxIssue   = (state_q == IDLE) && aux_req && !vdp_slot;
        auxBlocked = (state_q == IDLE) && aux_req && vdp_slot;
        state_d    = IDLE;
        if ((state_q == IDLE) && auxIssue) begin
            state_d = WAIT;
        end
    end

    // Reset gating keeps the bus quiet even if a VDP slot is presented while rst_n is low.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = lastAddr_q;
        ram_din  = 8'h00;
        if (!rst_n) begin
            ram_addr = '0;
        end else if (vdp_slot) begin
            ram_we   = vdp_we;
            ram_addr = vdp_addr;
            ram_din  = vdp_wdata;
        end else if (auxIssue) begin
            ram_we   = aux_we;
            ram_addr = aux_addr;
            ram_din  = aux_wdata;
        end
    end

    always_comb begin
        blkCnt_d = blkCnt_q;
        if (auxIssue) begin
            blkCnt_d = '0;
        end else if (auxBlocked && (blkCnt_q != BLK_MAX)) begin
            blkCnt_d = blkCnt_q + 1'b1;
        end
        starve_d = starve_q | (blkCnt_d == BLK_MAX);
    end

    // The RAM answers one cycle late, so the read data is passed through during the
    // cycle after the access and captured to hold until the next read of that requester.
    assign aux_ack    = (state_q == WAIT);
    assign aux_rdata  = aux_ack ? ram_dout : auxRdata_q;
    assign vdp_rdata  = vdpRdPend_q ? ram_dout : vdpRdata_q;
    assign aux_starve = starve_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastAddr_q  <= '0;
            auxRdata_q  <= 8'h00;
            vdpRdata_q  <= 8'h00;
            vdpRdPend_q <= 1'b0;
            blkCnt_q    <= '0;
            starve_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastAddr_q  <= ram_addr;
            auxRdata_q  <= aux_rdata;
            vdpRdata_q  <= vdp_rdata;
            vdpRdPend_q <= vdp_slot & ~vdp_we;
            blkCnt_q    <= blkCnt_d;
            starve_q    <= starve_d;
        end
    end

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] vdpCnt_q;
    logic [15:0] auxCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vdpCnt_q <= 16'h0000;
            auxCnt_q <= 16'h0000;
        end else begin
            if (vdp_slot && (vdpCnt_q != 16'hFFFF)) begin
                vdpCnt_q <= vdpCnt_q + 16'd1;
            end
            if (auxIssue && (auxCnt_q != 16'hFFFF)) begin
                auxCnt_q <= auxCnt_q + 16'd1;
            end
        end
    end

    assign vdp_cnt = vdpCnt_q;
    assign aux_cnt = auxCnt_q;
`else
    assign vdp_cnt = 16'h0000;
    assign aux_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a transaction-level model predicts bus activity,
// read results and flags; a monitor on the falling edge compares them with the DUT.
module tb_vram_arbiter;

    localparam int ADDR_W       = 15;
    localparam int STARVE_LIMIT = 255;
    localparam int RAM_DEPTH    = 1 << ADDR_W;
`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    typedef struct {
        int          cycle;
        logic [7:0]  data;
    } rdExp_t;

    typedef struct {
        int          cycle;
        logic [23:0] bus;
        logic        starve;
        logic [31:0] cnts;
    } busExp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              vdp_slot, vdp_we, aux_req, aux_we;
    logic [ADDR_W-1:0] vdp_addr, aux_addr;
    logic [7:0]        vdp_wdata, aux_wdata;
    logic [7:0]        vdp_rdata, aux_rdata, ram_din, ram_dout;
    logic              aux_ack, aux_starve, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       vdp_cnt, aux_cnt;

    vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .vdp_slot(vdp_slot), .vdp_we(vdp_we), .vdp_addr(vdp_addr),
        .vdp_wdata(vdp_wdata), .vdp_rdata(vdp_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
        .aux_wdata(aux_wdata), .aux_ack(aux_ack), .aux_rdata(aux_rdata),
        .aux_starve(aux_starve),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .vdp_cnt(vdp_cnt), .aux_cnt(aux_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous read-first RAM the arbiter drives.
    logic [7:0] ramMem [RAM_DEPTH];
    always @(posedge clk) begin
        ram_dout <= ramMem[ram_addr];
        if (ram_we) ramMem[ram_addr] <= ram_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state: memory image, pending aux request and flag/counter history.
    logic [7:0]        golden [RAM_DEPTH];
    bit                auxPend  = 1'b0;
    bit                ackCycle = 1'b0;
    logic              auxPWe   = 1'b0;
    logic [ADDR_W-1:0] auxPAddr = '0;
    logic [7:0]        auxPWd   = 8'h00;
    logic [ADDR_W-1:0] mLastAddr = '0;
    int                mBlk = 0;
    bit                mStarve = 1'b0;
    int                mVdpCnt = 0;
    int                mAuxCnt = 0;
    logic [7:0]        auxHeld = 8'h00;
    logic [7:0]        vdpHeld = 8'h00;

    busExp_t busQ[$];
    rdExp_t  auxQ[$];
    rdExp_t  vdpQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, actual, expected);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_ctrl"}, 32'({aux_ack, aux_starve, ram_we}), 32'd0);
        checkOutput({tag, "_rdata"}, 32'({aux_rdata, vdp_rdata}), 32'd0);
        checkOutput({tag, "_bus"}, 32'({ram_addr, ram_din}), 32'd0);
        checkOutput({tag, "_cnt"}, {vdp_cnt, aux_cnt}, 32'd0);
    endtask

    task automatic requestAux(input logic we, input logic [ADDR_W-1:0] addr, input logic [7:0] wd);
        auxPend  = 1'b1;
        auxPWe   = we;
        auxPAddr = addr;
        auxPWd   = wd;
    endtask

    // Drives one cycle of inputs and records what the arbiter must do in that cycle.
    task automatic applyStimulus(input logic slot, input logic vwe, input logic [ADDR_W-1:0] vaddr, input logic [7:0] vwd);
        busExp_t e;
        rdExp_t  r;
        bit      req;
        @(posedge clk);
        #1;
        vdp_slot  = slot;
        vdp_we    = vwe;
        vdp_addr  = vaddr;
        vdp_wdata = vwd;
        req       = auxPend && !ackCycle;
        ackCycle  = 1'b0;
        aux_req   = req;
        aux_we    = auxPWe;
        aux_addr  = auxPAddr;
        aux_wdata = auxPWd;
        e.cycle  = cyc;
        e.starve = mStarve;
        e.cnts   = {16'(mVdpCnt), 16'(mAuxCnt)};
        e.bus    = {1'b0, mLastAddr, 8'h00};
        if (slot) begin
            e.bus     = {vwe, vaddr, vwd};
            mLastAddr = vaddr;
            if (STATS_ON && mVdpCnt < 65535) mVdpCnt++;
            if (vwe) golden[vaddr] = vwd;
            else begin
                r.cycle = cyc + 1;
                r.data  = golden[vaddr];
                vdpQ.push_back(r);
            end
            if (req) begin
                if (mBlk < STARVE_LIMIT) mBlk++;
                if (mBlk >= STARVE_LIMIT) mStarve = 1'b1;
            end
        end else if (req) begin
            e.bus     = {auxPWe, auxPAddr, auxPWd};
            mLastAddr = auxPAddr;
            r.cycle   = cyc + 1;
            r.data    = golden[auxPAddr];
            auxQ.push_back(r);
            if (auxPWe) golden[auxPAddr] = auxPWd;
            mBlk = 0;
            if (STATS_ON && mAuxCnt < 65535) mAuxCnt++;
            auxPend  = 1'b0;
            ackCycle = 1'b1;
        end
        busQ.push_back(e);
    endtask

    task automatic resetInWait();
        @(posedge clk);
        #1;
        vdp_slot  = 1'b1;
        vdp_we    = 1'b1;
        vdp_addr  = 15'h0ABC;
        vdp_wdata = 8'hFF;
        aux_req   = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkResetOutputs("rst_in_wait");
        busQ.delete();
        auxQ.delete();
        vdpQ.delete();
        auxPend   = 1'b0;
        ackCycle  = 1'b0;
        mLastAddr = '0;
        mBlk      = 0;
        mStarve   = 1'b0;
        mVdpCnt   = 0;
        mAuxCnt   = 0;
        auxHeld   = 8'h00;
        vdpHeld   = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        vdp_slot = 1'b0;
        vdp_we   = 1'b0;
        #1 checkResetOutputs("rst_held");
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [ADDR_W-1:0] randAddr();
        if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom);
        return ADDR_W'($urandom_range(0, 15));
    endfunction

    // Monitor: compares every driven cycle against the scoreboard entries.
    busExp_t monE;
    rdExp_t  monR;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (busQ.size() > 0 && busQ[0].cycle == cyc) begin
                    monE = busQ.pop_front();
                    checkOutput("ram_bus", 32'({ram_we, ram_addr, ram_din}), 32'(monE.bus));
                    checkOutput("aux_starve", 32'(aux_starve), 32'(monE.starve));
                    checkOutput("stat_counters", {vdp_cnt, aux_cnt}, monE.cnts);
                end
                if (aux_ack === 1'b1) begin
                    if (auxQ.size() == 0) begin
                        checkOutput("aux_ack_unexpected", 32'(aux_ack), 32'd0);
                    end else begin
                        monR = auxQ.pop_front();
                        checkOutput("aux_ack_cycle", cyc, monR.cycle);
                        checkOutput("aux_rdata", 32'(aux_rdata), 32'(monR.data));
                        auxHeld = monR.data;
                    end
                end else begin
                    if (auxQ.size() > 0 && auxQ[0].cycle <= cyc) begin
                        monR = auxQ.pop_front();
                        checkOutput("aux_ack_missing", 32'(aux_ack), 32'd1);
                    end
                    checkOutput("aux_rdata_hold", 32'(aux_rdata), 32'(auxHeld));
                end
                if (vdpQ.size() > 0 && vdpQ[0].cycle == cyc) begin
                    monR = vdpQ.pop_front();
                    checkOutput("vdp_rdata", 32'(vdp_rdata), 32'(monR.data));
                    vdpHeld = monR.data;
                end else begin
                    checkOutput("vdp_rdata_hold", 32'(vdp_rdata), 32'(vdpHeld));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        vdp_slot  = 1'b0;
        vdp_we    = 1'b0;
        vdp_addr  = '0;
        vdp_wdata = 8'h00;
        aux_req   = 1'b0;
        aux_we    = 1'b0;
        aux_addr  = '0;
        aux_wdata = 8'h00;
        for (int i = 0; i < RAM_DEPTH; i++) begin
            ramMem[i] <= 8'(i * 13 + 7);
            golden[i] = 8'(i * 13 + 7);
        end
        #12 checkResetOutputs("por");
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Aux write then read-back with no VDP traffic.
        requestAux(1'b1, 15'h1234, 8'hA5);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        requestAux(1'b0, 15'h1234, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);

        // Aux request colliding with a VDP write slot is deferred.
        requestAux(1'b0, 15'h0010, 8'h00);
        applyStimulus(1'b1, 1'b1, 15'h0010, 8'h3C);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);

        // VDP read followed by an aux read; VDP data must hold.
        applyStimulus(1'b1, 1'b0, 15'h0010, 8'h00);
        requestAux(1'b0, 15'h7FFF, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);

        // Starvation: aux blocked for STARVE_LIMIT cycles, flag sticks past the grant.
        requestAux(1'b0, 15'h0100, 8'h00);
        for (int i = 0; i < STARVE_LIMIT; i++) begin
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);

        // Reset while the aux access is waiting for its data.
        requestAux(1'b0, 15'h0005, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        resetInWait();

        // Three VDP slots and two aux accesses, including VDP traffic in the ack cycle.
        requestAux(1'b1, 15'h0021, 8'h22);
        applyStimulus(1'b1, 1'b0, 15'h0020, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b1, 1'b1, 15'h0022, 8'h33);
        requestAux(1'b0, 15'h0021, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        applyStimulus(1'b1, 1'b0, 15'h0021, 8'h00);
        applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        #2 checkOutput("counter_totals", {vdp_cnt, aux_cnt}, STATS_ON ? {16'd3, 16'd2} : 32'd0);

        // Randomized mixed traffic.
        for (int i = 0; i < 600; i++) begin
            if (!auxPend && $urandom_range(0, 2) == 0) begin
                requestAux(1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
            end
            applyStimulus(1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 1)), randAddr(), 8'($urandom));
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 15'h0000, 8'h00);
        end
        @(negedge clk);
        #1;
        checkOutput("aux_queue_drained", 32'(auxQ.size()), 32'd0);
        checkOutput("vdp_queue_drained", 32'(vdpQ.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: VRAM address width (32 KB).
REQ-002 SHALL have parameter STARVE_LIMIT, default 255: number of blocked aux cycles before the starvation flag sets.
REQ-003 SHALL have port clk  in  1: single clock (pixel clock domain); all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port vdp_slot  in  1: VDP access slot (VideoDLClk qualifier).
REQ-006 SHALL have port vdp_we  in  1: VDP write; a read is implied when low.
REQ-007 SHALL have port vdp_addr  in  ADDR_W: VDP address.
REQ-008 SHALL have port vdp_wdata  in  8: VDP write data.
REQ-009 SHALL have port vdp_rdata  out  8: VDP read data.
REQ-010 SHALL have port aux_req  in  1: aux request, level; addr/we/wdata held stable while high.
REQ-011 SHALL have port aux_we  in  1: aux write.
REQ-012 SHALL have port aux_addr  in  ADDR_W: aux address.
REQ-013 SHALL have port aux_wdata  in  8: aux write data.
REQ-014 SHALL have port aux_ack  out  1: one-cycle completion pulse.
REQ-015 SHALL have port aux_rdata  out  8: aux read data, valid with aux_ack.
REQ-016 SHALL have port aux_starve  out  1: sticky starvation flag.
REQ-017 SHALL have port ram_we  out  1: RAM write enable.
REQ-018 SHALL have port ram_addr  out  ADDR_W: RAM address.
REQ-019 SHALL have port ram_din  out  8: RAM write data.
REQ-020 SHALL have port ram_dout  in  8: RAM read data, synchronous (address at cycle t gives data at t+1).
REQ-021 SHALL have port vdp_cnt  out  16: VDP access count.
REQ-022 SHALL have port aux_cnt  out  16: aux access count.

Function
REQ-023 SHALL give VDP absolute priority: when vdp_slot=1, ram_addr=vdp_addr, ram_din=vdp_wdata, ram_we=vdp_we, combinationally.
REQ-024 SHALL implement FSM states IDLE and WAIT.
REQ-025 SHALL issue the aux access in IDLE when aux_req=1 and vdp_slot=0: same cycle, ram_addr=aux_addr, ram_din=aux_wdata, ram_we=aux_we; next state WAIT.
REQ-026 SHALL drive, when neither VDP nor aux issues: ram_we=0, ram_addr=last driven address, ram_din=0.
REQ-027 SHALL in WAIT assert aux_ack=1 for exactly one cycle, drive aux_rdata=ram_dout combinationally, and return to IDLE.
REQ-028 SHALL hold aux_rdata at its last captured value outside WAIT.
REQ-029 SHALL drive vdp_rdata=ram_dout in the cycle after a VDP read slot, then hold that value until the next VDP read.
REQ-030 SHALL let vdp_slot=1 during WAIT proceed to the RAM, with no corruption of the aux result (aux data comes from the issue cycle).
REQ-031 SHALL sample aux_req only in IDLE; aux_req still high after ack starts a new transaction; requesters deassert in the ack cycle.
REQ-032 SHALL count with a saturating counter every cycle that aux_req=1 in IDLE is blocked by vdp_slot; the counter clears on issue.
REQ-033 SHALL set aux_starve when the blocked counter reaches STARVE_LIMIT; aux_starve stays set until reset.
REQ-034 SHALL NOT allow more than one RAM access per cycle; ram_we is never asserted for both requesters.

Reset
REQ-035 SHALL on rst_n=0 immediately force: state=IDLE, aux_ack=0, aux_rdata=0, vdp_rdata=0, aux_starve=0, ram_addr=0, ram_we=0, ram_din=0, counters=0.
REQ-036 SHALL on reset during WAIT drop the pending aux transaction with no ack, and ignore the first post-reset ram_dout.

Configuration
REQ-037 SHALL, with macro VRAM_ARB_STATS_EN defined, increment vdp_cnt on each vdp_slot cycle and aux_cnt on each aux issue, each saturating at 16'hFFFF.
REQ-038 SHALL, without VRAM_ARB_STATS_EN, tie vdp_cnt and aux_cnt to 16'h0000 and generate no counter logic.

Verification
REQ-039 SHALL cover: aux write 0x1234<-0xA5 with vdp_slot=0 -> ram_we=1 at addr 0x1234 in the same cycle, aux_ack next cycle; aux read 0x1234 -> aux_rdata=0xA5 with ack.
REQ-040 SHALL cover: aux_req and vdp_slot rise together, VDP writes 0x0010<-0x3C -> ram_addr=0x0010, aux is deferred until vdp_slot=0, then ack after 1 cycle.
REQ-041 SHALL cover: VDP read 0x0010 then aux read 0x7FFF in the next cycle -> vdp_rdata=0x3C and holds 0x3C after the aux read completes.
REQ-042 SHALL cover: vdp_slot held high for 255 cycles with aux_req=1 -> aux_starve=1 at cycle 255 and stays 1 after the grant.
REQ-043 SHALL cover: rst_n=0 asserted in WAIT -> no aux_ack, all outputs 0 asynchronously, IDLE after release.
REQ-044 SHALL cover: with VRAM_ARB_STATS_EN, 3 VDP slots and 2 aux accesses -> vdp_cnt=3, aux_cnt=2; without the macro -> both counters read 0.
